// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM bank between the instruction and data buses.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data wins every tie.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic              start_s;
    logic              grant_data_s;
    logic              capture_s;

    logic              owner_data_r;
    logic              owner_data_next_s;
    logic              we_r;
    logic              we_next_s;
    logic [3:0]        be_r;
    logic [3:0]        be_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [31:0]       wdata_r;
    logic [31:0]       wdata_next_s;

    logic              ce_n_s;
    logic              oe_n_s;
    logic              we_n_s;
    logic [3:0]        be_n_s;
    logic              dq_oe_s;
    logic [ADDR_W-1:0] sram_addr_s;
    logic [31:0]       dq_o_s;
    logic              inst_ack_s;
    logic              data_ack_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_data_r;

    // Tie-break goes to the port that did not win the previous grant.
    always_comb begin
        if (inst_req && data_req) begin
            grant_data_s = ~last_grant_data_r;
        end else if (data_req) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // Track the most recent grant (reset value means instruction).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_data_r <= 1'b0;
        end else if (start_s) begin
            last_grant_data_r <= grant_data_s;
        end else begin
            last_grant_data_r <= last_grant_data_r;
        end
    end
`else
    // Fixed priority: the data port wins every tie, instruction may starve.
    always_comb begin
        if (data_req) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
    end
`endif

    // FSM state and access counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic and latching of the winner's request fields.
    always_comb begin
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        start_s           = 1'b0;
        owner_data_next_s = owner_data_r;
        we_next_s         = we_r;
        be_next_s         = be_r;
        addr_next_s       = addr_r;
        wdata_next_s      = wdata_r;
        case (state_r)
            IDLE: begin
                if (inst_req || data_req) begin
                    start_s           = 1'b1;
                    state_next_s      = ACCESS;
                    cnt_next_s        = 4'd0;
                    owner_data_next_s = grant_data_s;
                    if (grant_data_s) begin
                        we_next_s    = data_we;
                        be_next_s    = data_be;
                        addr_next_s  = data_addr;
                        wdata_next_s = data_wdata;
                    end else begin
                        we_next_s    = 1'b0;
                        be_next_s    = 4'hF;
                        addr_next_s  = inst_addr;
                        wdata_next_s = 32'h0000_0000;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = DONE;
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = ACCESS;
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered pins line up with the state.
    always_comb begin
        ce_n_s      = 1'b1;
        oe_n_s      = 1'b1;
        we_n_s      = 1'b1;
        be_n_s      = 4'hF;
        dq_oe_s     = 1'b0;
        sram_addr_s = sram_addr;
        dq_o_s      = sram_dq_o;
        inst_ack_s  = 1'b0;
        data_ack_s  = 1'b0;
        capture_s   = (state_r == ACCESS) && (cnt_r == LAST_CNT) && !we_r;
        if (state_next_s == ACCESS) begin
            ce_n_s      = 1'b0;
            be_n_s      = ~be_next_s;
            sram_addr_s = addr_next_s;
            if (we_next_s) begin
                dq_oe_s = 1'b1;
                dq_o_s  = wdata_next_s;
                // Release we_n one cycle early so data and address are held past the strobe.
                we_n_s  = (cnt_next_s < LAST_CNT) ? 1'b0 : 1'b1;
            end else begin
                oe_n_s = 1'b0;
            end
        end else if (state_next_s == DONE) begin
            inst_ack_s = ~owner_data_next_s;
            data_ack_s = owner_data_next_s;
        end else begin
            inst_ack_s = 1'b0;
            data_ack_s = 1'b0;
        end
    end

    // Transaction latch, SRAM pin registers, acknowledges and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_data_r <= 1'b0;
            we_r         <= 1'b0;
            be_r         <= 4'hF;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= 32'h0000_0000;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_dq_oe   <= 1'b0;
            sram_addr    <= {ADDR_W{1'b0}};
            sram_dq_o    <= 32'h0000_0000;
            inst_ack     <= 1'b0;
            data_ack     <= 1'b0;
            inst_rdata   <= 32'h0000_0000;
            data_rdata   <= 32'h0000_0000;
        end else begin
            owner_data_r <= owner_data_next_s;
            we_r         <= we_next_s;
            be_r         <= be_next_s;
            addr_r       <= addr_next_s;
            wdata_r      <= wdata_next_s;
            sram_ce_n    <= ce_n_s;
            sram_oe_n    <= oe_n_s;
            sram_we_n    <= we_n_s;
            sram_be_n    <= be_n_s;
            sram_dq_oe   <= dq_oe_s;
            sram_addr    <= sram_addr_s;
            sram_dq_o    <= dq_o_s;
            inst_ack     <= inst_ack_s;
            data_ack     <= data_ack_s;
            if (capture_s && !owner_data_r) begin
                inst_rdata <= sram_dq_i;
            end else begin
                inst_rdata <= inst_rdata;
            end
            if (capture_s && owner_data_r) begin
                data_rdata <= sram_dq_i;
            end else begin
                data_rdata <= data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM pin model, transaction-level reference, directed and random traffic.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int W  = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [3:0] EXP_ORD = RR ? 4'b1010 : 4'b1111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [31:0]   inst_rdata;
    logic          inst_ack;
    logic          data_req;
    logic          data_we;
    logic [3:0]    data_be;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic [31:0]   data_rdata;
    logic          data_ack;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [31:0]   sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        case (i)
            'h00:    return 32'h1111_0000;
            'h01:    return 32'h1111_0001;
            'h05:    return 32'h5555_0005;
            'h06:    return 32'h6666_0006;
            'h10:    return 32'hDEAD_BEEF;
            'h31:    return 32'hCAFE_0031;
            default: return {b, 8'hA5, ~b, 8'h3C};
        endcase
    endfunction

    function automatic logic [31:0] bemerge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // SRAM pin model: data becomes valid only once oe_n has been low for the full access time.
    logic [31:0] sram_mem [256];
    logic        mem_ready = 1'b0;
    int          oe_cnt = 0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[7:0]] <= bemerge(sram_mem[sram_addr[7:0]], sram_dq_o, ~sram_be_n);
        end
        if (!sram_ce_n && !sram_oe_n) oe_cnt <= oe_cnt + 1;
        else oe_cnt <= 0;
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n && oe_cnt >= W - 1) ? sram_mem[sram_addr[7:0]] : 32'hA5A5_5A5A;

    // Reference model: one transaction at a time, phase 0 idle, 1..W access, W+1 acknowledge.
    logic [31:0]   gold [256];
    logic          gold_ready = 1'b0;
    int            ph = 0;
    logic          m_data = 1'b0, m_we = 1'b0, last_data = 1'b0;
    logic [3:0]    m_be = 4'h0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_wd = 32'h0, exp_irdata = 32'h0, exp_drdata = 32'h0;
    logic          g_data;
    assign g_data = (inst_req && data_req) ? (RR ? ~last_data : 1'b1) : data_req;

    always @(posedge clk or negedge rst_n) begin
        if (!gold_ready) begin
            for (int i = 0; i < 256; i++) gold[i] <= init_val(i);
            gold_ready <= 1'b1;
        end
        if (!rst_n) begin
            ph <= 0; last_data <= 1'b0; exp_irdata <= 32'h0; exp_drdata <= 32'h0;
            m_data <= 1'b0; m_we <= 1'b0; m_be <= 4'h0; m_addr <= '0; m_wd <= 32'h0;
        end else if (ph == 0) begin
            if (inst_req || data_req) begin
                ph        <= 1;
                m_data    <= g_data;
                last_data <= g_data;
                m_we      <= g_data ? data_we : 1'b0;
                m_be      <= g_data ? data_be : 4'hF;
                m_addr    <= g_data ? data_addr : inst_addr;
                m_wd      <= g_data ? data_wdata : 32'h0;
            end
        end else if (ph == W) begin
            ph <= W + 1;
            if (m_we) gold[m_addr[7:0]] <= bemerge(gold[m_addr[7:0]], m_wd, m_be);
            else if (m_data) exp_drdata <= gold[m_addr[7:0]];
            else exp_irdata <= gold[m_addr[7:0]];
        end else if (ph == W + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    logic       e_acc, e_done;
    logic [3:0] e_be_n;
    assign e_acc  = (ph >= 1) && (ph <= W);
    assign e_done = (ph == W + 1);
    assign e_be_n = e_acc ? ~m_be : 4'hF;

    // Compare every DUT output against the reference on each falling edge.
    always @(negedge clk) begin
        if (rst_n && gold_ready) begin
            check("ce_n", 32'(sram_ce_n), 32'(!e_acc));
            check("oe_n", 32'(sram_oe_n), 32'(!(e_acc && !m_we)));
            check("we_n", 32'(sram_we_n), 32'(!(e_acc && m_we && ph < W)));
            check("be_n", 32'(sram_be_n), 32'(e_be_n));
            check("dq_oe", 32'(sram_dq_oe), 32'(e_acc && m_we));
            check("inst_ack", 32'(inst_ack), 32'(e_done && !m_data));
            check("data_ack", 32'(data_ack), 32'(e_done && m_data));
            check("inst_rdata", inst_rdata, exp_irdata);
            check("data_rdata", data_rdata, exp_drdata);
            if (e_acc) check("sram_addr", 32'(sram_addr), 32'(m_addr));
            if (e_acc && m_we) check("dq_o", sram_dq_o, m_wd);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic data_txn(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                            input logic [31:0] wd, output int lat, output int ce_low, output int oe_low,
                            output int we_low, output int dq_oe_cnt, output int iack, output logic [3:0] ben);
        step();
        data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
        lat = 0; ce_low = 0; oe_low = 0; we_low = 0; dq_oe_cnt = 0; iack = 0; ben = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!sram_ce_n) begin ce_low++; ben = sram_be_n; end
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) dq_oe_cnt++;
            if (inst_ack) iack++;
            if (data_ack) begin lat = k; break; end
        end
        data_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 255));
    endfunction

    int lat, ce_low, oe_low, we_low, dq_cnt, iack, n_acks, n_inst, t_first, t_second;
    logic [3:0] ben, ord;

    initial begin
        rst_n = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
        data_be = 4'h0; data_addr = '0; data_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_be_n", 32'(sram_be_n), 32'hF);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_o", sram_dq_o, 32'h0);
        check("rst_acks", 32'({inst_ack, data_ack}), 32'h0);
        check("rst_rdata", inst_rdata | data_rdata, 32'h0);
        rst_n = 1'b1;

        // Single data read.
        data_txn(1'b0, 4'hF, 20'h00010, 32'h0, lat, ce_low, oe_low, we_low, dq_cnt, iack, ben);
        check("read_latency", 32'(lat), 32'd3);
        check("read_ce_low", 32'(ce_low), 32'd2);
        check("read_oe_low", 32'(oe_low), 32'd2);
        check("read_inst_ack", 32'(iack), 32'd0);
        check("read_rdata", data_rdata, 32'hDEAD_BEEF);

        // Byte write.
        data_txn(1'b1, 4'b0010, 20'h00020, 32'h1234_5678, lat, ce_low, oe_low, we_low, dq_cnt, iack, ben);
        check("write_latency", 32'(lat), 32'd3);
        check("write_we_low", 32'(we_low), 32'd1);
        check("write_oe_low", 32'(oe_low), 32'd0);
        check("write_dq_oe", 32'(dq_cnt), 32'd2);
        check("write_be_n", 32'(ben), 32'b1101);
        check("write_mem", sram_mem[32], 32'h20A5_563C);

        // Simultaneous held requests after a fresh reset.
        step(); rst_n = 1'b0; step(); rst_n = 1'b1;
        inst_req = 1'b1; inst_addr = 20'h00040;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 20'h00041;
        ord = 4'h0; n_acks = 0; n_inst = 0;
        for (int k = 0; k < 40 && n_acks < 4; k++) begin
            step();
            if (inst_ack || data_ack) begin
                ord = {ord[2:0], data_ack};
                n_acks++;
                if (inst_ack) n_inst++;
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        check("tie_acks", 32'(n_acks), 32'd4);
        check("tie_order", 32'(ord), 32'(EXP_ORD));
        check("tie_inst_acks", 32'(n_inst), RR ? 32'd2 : 32'd0);

        // Back-to-back instruction fetch with req held across the ack.
        step();
        inst_req = 1'b1; inst_addr = 20'h00000;
        t_first = 0; t_second = 0; n_acks = 0;
        for (int k = 1; k <= 30 && n_acks < 2; k++) begin
            step();
            if (inst_ack) begin
                n_acks++;
                if (n_acks == 1) begin
                    t_first = k;
                    check("b2b_word0", inst_rdata, 32'h1111_0000);
                    inst_addr = 20'h00001;
                end else begin
                    t_second = k;
                    check("b2b_word1", inst_rdata, 32'h1111_0001);
                end
            end
        end
        inst_req = 1'b0;
        check("b2b_first_lat", 32'(t_first), 32'd3);
        check("b2b_spacing", 32'(t_second - t_first), 32'd4);

        // Reset during the first cycle of a write.
        step();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 20'h00030; data_wdata = 32'h0BAD_BEEF;
        step();
        check("abort_we_started", 32'(sram_we_n), 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'h1);
        check("abort_ce_n", 32'(sram_ce_n), 32'h1);
        data_req = 1'b0;
        step();
        check("abort_no_ack", 32'({inst_ack, data_ack}), 32'h0);
        rst_n = 1'b1;
        data_txn(1'b0, 4'hF, 20'h00031, 32'h0, lat, ce_low, oe_low, we_low, dq_cnt, iack, ben);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata", data_rdata, 32'hCAFE_0031);

        // Address change after grant must be ignored.
        step();
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 20'h00005;
        step();
        check("hold_addr_c1", 32'(sram_addr), 32'h5);
        data_addr = 20'h00006;
        step();
        check("hold_addr_c2", 32'(sram_addr), 32'h5);
        step();
        check("hold_ack", 32'(data_ack), 32'h1);
        check("hold_rdata", data_rdata, 32'h5555_0005);
        data_req = 1'b0;

        // Randomised traffic on both ports, with field changes while waiting.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (inst_req) begin
                if (inst_ack) begin
                    if ($urandom_range(0, 1) == 0) inst_req = 1'b0;
                    else inst_addr = rand_addr();
                end else if ($urandom_range(0, 3) == 0) inst_addr = rand_addr();
            end else if ($urandom_range(0, 2) == 0) begin
                inst_req = 1'b1; inst_addr = rand_addr();
            end
            if (data_req && !data_ack) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_addr = rand_addr(); data_wdata = $urandom(); data_we = 1'($urandom_range(0, 1));
                end
            end else if (data_req && data_ack && $urandom_range(0, 1) == 0) begin
                data_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                data_req = 1'b1; data_we = 1'($urandom_range(0, 1)); data_be = 4'($urandom_range(0, 15));
                data_addr = rand_addr(); data_wdata = $urandom();
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        repeat (8) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
